// File: rtl/audio_sample_fifo_pkg.sv
// audio_sample_fifo_pkg: shared DAC datapath constants (sample width, FIFO depth, OSR codes)
package audio_sample_fifo_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_LOG2_DEF = 4;
  typedef enum logic [1:0] {
    OSR_32  = 2'b00,
    OSR_64  = 2'b01,
    OSR_128 = 2'b10,
    OSR_256 = 2'b11
  } osr_e;
endpackage

// File: rtl/audio_fifo_mem.sv
// audio_fifo_mem: DEPTH x DATA_W register array, one write port, one asynchronous read port
module audio_fifo_mem
  import audio_sample_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = DEPTH_LOG2_DEF
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: host-to-DAC sample FIFO with registered output, level and sticky underflow.
// AUDIO_FIFO_MUTE_ON_UNDERFLOW_EN: when defined, an empty pop mutes sample_o and pulses sample_upd_o.
module audio_sample_fifo
  import audio_sample_fifo_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  logic                audio_rd_i,
  output logic [DATA_W-1:0]   sample_o,
  output logic                sample_upd_o,
  output logic [DEPTH_LOG2:0] level_o,
  output logic                underflow_o,
  input  logic                clr_underflow_i
);
  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam logic [LVL_W-1:0] DEPTH = LVL_W'(2**DEPTH_LOG2);
`ifdef AUDIO_FIFO_MUTE_ON_UNDERFLOW_EN
  localparam logic MUTE = 1'b1;
`else
  localparam logic MUTE = 1'b0;
`endif
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [DATA_W-1:0]     sample_q, sample_d, head;
  logic                  upd_q, upd_d, uf_q, uf_d;
  logic                  push, pop, empty_rd;
  audio_fifo_mem #(.DATA_W(DATA_W), .ADDR_W(DEPTH_LOG2)) u_mem (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );
  // Ready comes from the registered level only, so a full FIFO refuses a push even during a pop.
  assign wr_ready_o = level_q != DEPTH;
  assign push       = wr_valid_i & wr_ready_o;
  assign pop        = audio_rd_i & (level_q != '0);
  assign empty_rd   = audio_rd_i & (level_q == '0);
  always_comb begin
    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(push);
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop);
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    sample_d = pop ? head : (MUTE & empty_rd) ? '0 : sample_q;
    upd_d    = pop | (MUTE & empty_rd);
    uf_d     = clr_underflow_i ? 1'b0 : (uf_q | empty_rd);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      sample_q <= '0;
      upd_q    <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      sample_q <= sample_d;
      upd_q    <= upd_d;
      uf_q     <= uf_d;
    end
  end
  assign sample_o     = sample_q;
  assign sample_upd_o = upd_q;
  assign level_o      = level_q;
  assign underflow_o  = uf_q;
endmodule

// File: tb/tb_audio_sample_fifo.sv
// tb_audio_sample_fifo: directed scenarios plus random traffic checked against a queue-based model
module tb_audio_sample_fifo;
  localparam int DEPTH = 16;
`ifdef AUDIO_FIFO_MUTE_ON_UNDERFLOW_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_valid = 1'b0, audio_rd = 1'b0, clr_uf = 1'b0;
  logic        wr_ready, sample_upd, underflow;
  logic [15:0] sample;
  logic [4:0]  level;
  int          n_chk = 0, n_pass = 0;
  logic [15:0] q [$];
  logic [15:0] m_sample = '0;
  bit          m_upd = 1'b0, m_uf = 1'b0;
  audio_sample_fifo dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .wr_data_i       (wr_data),
    .wr_valid_i      (wr_valid),
    .wr_ready_o      (wr_ready),
    .audio_rd_i      (audio_rd),
    .sample_o        (sample),
    .sample_upd_o    (sample_upd),
    .level_o         (level),
    .underflow_o     (underflow),
    .clr_underflow_i (clr_uf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".level"}, 32'(level), 32'(q.size()));
    chk({tag, ".ready"}, 32'(wr_ready), 32'(q.size() != DEPTH));
    chk({tag, ".sample"}, 32'(sample), 32'(m_sample));
    chk({tag, ".upd"}, 32'(sample_upd), 32'(m_upd));
    chk({tag, ".uf"}, 32'(underflow), 32'(m_uf));
  endtask
  task automatic cyc(input string tag, input bit wv, input logic [15:0] wd, input bit rd, input bit cl, input bit rs);
    bit push, pop, emp;
    rst = rs; wr_valid = wv; wr_data = wd; audio_rd = rd; clr_uf = cl;
    push = wv && q.size() < DEPTH;
    pop  = rd && q.size() > 0;
    emp  = rd && q.size() == 0;
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete(); m_sample = '0; m_upd = 1'b0; m_uf = 1'b0;
    end else begin
      m_upd = pop || (MUTE && emp);
      if (pop) m_sample = q.pop_front();
      else if (MUTE && emp) m_sample = '0;
      if (push) q.push_back(wd);
      m_uf = !cl && (m_uf || emp);
    end
    rst = 1'b0; wr_valid = 1'b0; audio_rd = 1'b0; clr_uf = 1'b0;
    check_all(tag);
  endtask
  initial begin
    cyc("reset", 0, 0, 0, 0, 1);
    chk("reset.ready_one", 32'(wr_ready), 32'd1);
    // Scenario 1: three pushes then three strobes, value visible 1 clk after each strobe
    cyc("t1.push", 1, 16'h1234, 0, 0, 0);
    cyc("t1.push", 1, 16'h8000, 0, 0, 0);
    cyc("t1.push", 1, 16'h7FFF, 0, 0, 0);
    cyc("t1.pop", 0, 0, 1, 0, 0); chk("t1.s0", 32'(sample), 32'h1234); chk("t1.u0", 32'(sample_upd), 1);
    cyc("t1.gap", 0, 0, 0, 0, 0); chk("t1.hold", 32'(sample_upd), 0);
    cyc("t1.pop", 0, 0, 1, 0, 0); chk("t1.s1", 32'(sample), 32'h8000);
    cyc("t1.pop", 0, 0, 1, 0, 0); chk("t1.s2", 32'(sample), 32'h7FFF);
    // Scenario 2: fill to full, then push+strobe together; push must be refused
    for (int i = 0; i < DEPTH; i++) cyc("t2.fill", 1, 16'(i * 3 + 1), 0, 0, 0);
    chk("t2.full_level", 32'(level), 32'd16);
    chk("t2.full_ready", 32'(wr_ready), 32'd0);
    cyc("t2.push_pop_full", 1, 16'hDEAD, 1, 0, 0);
    chk("t2.level15", 32'(level), 32'd15);
    for (int i = 0; i < 15; i++) cyc("t2.drain", 0, 0, 1, 0, 0);
    chk("t2.last_word", 32'(sample), 32'd46);
    // Scenario 3: empty strobe with sample 0x0ABC
    cyc("t3.push", 1, 16'h0ABC, 0, 0, 0);
    cyc("t3.pop", 0, 0, 1, 0, 0);
    cyc("t3.empty_pop", 1, 16'h5555, 1, 0, 0);
    chk("t3.uf", 32'(underflow), 32'd1);
    chk("t3.sample", 32'(sample), MUTE ? 32'd0 : 32'h0ABC);
    chk("t3.upd", 32'(sample_upd), 32'(MUTE));
    chk("t3.stored", 32'(level), 32'd1);
    // Scenario 5: clear beats a simultaneous new underflow
    cyc("t5.drain", 0, 0, 1, 0, 0);
    cyc("t5.clr_and_empty", 0, 0, 1, 1, 0);
    chk("t5.uf_clr", 32'(underflow), 32'd0);
    // Scenario 4: level 5, push+pop keeps level and outputs oldest word
    cyc("t4.rst", 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc("t4.fill", 1, 16'hA000 + 16'(i), 0, 0, 0);
    cyc("t4.push_pop", 1, 16'hBEEF, 1, 0, 0);
    chk("t4.level5", 32'(level), 32'd5);
    chk("t4.oldest", 32'(sample), 32'hA000);
    // Scenario 6: mid-stream reset at level 8
    for (int i = 0; i < 3; i++) cyc("t6.fill", 1, 16'h0C00 + 16'(i), 0, 0, 0);
    cyc("t6.pop", 0, 0, 1, 0, 0);
    cyc("t6.empty_pre", 0, 0, 0, 0, 0);
    chk("t6.level8", 32'(level), 32'd7);
    cyc("t6.fill8", 1, 16'h0CFF, 0, 0, 0);
    chk("t6.level8b", 32'(level), 32'd8);
    cyc("t6.rst", 1, 16'h1111, 1, 0, 1);
    chk("t6.lvl0", 32'(level), 0); chk("t6.s0", 32'(sample), 0);
    chk("t6.uf0", 32'(underflow), 0); chk("t6.rdy", 32'(wr_ready), 1);
    // Random traffic with phases biased toward filling, draining and balance
    for (int i = 0; i < 600; i++) begin
      int ph;
      bit wv, rd;
      ph = (i / 75) % 4;
      wv = $urandom_range(99) < (ph == 0 ? 85 : ph == 1 ? 20 : 50);
      rd = $urandom_range(99) < (ph == 0 ? 20 : ph == 1 ? 85 : 50);
      cyc("rand", wv, 16'($urandom), rd, $urandom_range(19) == 0, $urandom_range(199) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
